instruction_fetch_responder: RTL and testbench

- Responder end of the PC-to-instruction-memory interface.
- Accepts a 64-bit byte address (the PC) with a req/ready handshake and returns the addressed 32-bit LEGv8 instruction after a programmable number of wait states.
- Flags misaligned and out-of-range fetches.
- Holds a word-addressed instruction store, programmed through a side load port before or during execution.

---
 rtl/instruction_fetch_responder.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_responder.sv
// instruction_fetch_responder
//   Responder end of the PC-to-instruction-memory link. It accepts a byte
//   address with a req/ready handshake. After WAIT_STATES extra cycles it
//   returns the addressed 32-bit instruction word from a word-addressed
//   store. Misaligned and out-of-range addresses are answered with fault=1
//   one edge after acceptance. The store is written through a side load
//   port at any time.
//
// Ports:
//   clock      rising-edge system clock
//   reset      asynchronous, active-low reset
//   req        fetch request, taken when ready=1
//   addr       64-bit byte address (PC) of the requested instruction
//   ready      responder can accept a request this cycle
//   valid      one-cycle pulse; instr/fault carry the response
//   instr      fetched instruction word (held until the next response)
//   fault      with valid: fetch was misaligned or out of range
//   load_en    store write enable
//   load_addr  word index to write
//   load_data  instruction word to write
module instruction_fetch_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [63:0]           addr,
  output logic                  ready,
  output logic                  valid,
  output logic [31:0]           instr,
  output logic                  fault,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // The counter counts down the remaining wait cycles. It ends at zero on the edge that enters RESP.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [31:0] mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [31:0]           instr_q, instr_d;
  logic                  fault_q, fault_d;

  logic                  accept;
  logic                  addr_mis;
  logic                  addr_oor;
  logic [DEPTH_LOG2-1:0] addr_idx;

  assign accept   = req && ready_q;
  assign addr_mis = (addr[1:0] != 2'b00);
  assign addr_oor = |addr[63:DEPTH_LOG2+2];
  assign addr_idx = addr[DEPTH_LOG2+1:2];

  // Next-state logic. The store is read combinationally here, so the word
  // registered into instr_q is the content from before any load on the same
  // edge. This makes a collision read-before-write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    fault_d = fault_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          instr_d = mem[idx_q];
          fault_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // IDLE and RESP both accept. A request taken in RESP gives back-to-back responses.
        if (accept) begin
          idx_d = addr_idx;
          if (addr_mis || addr_oor) begin
            state_d = S_RESP;
            instr_d = 32'h0;
            fault_d = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            instr_d = mem[addr_idx];
            fault_d = 1'b0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    ready_d = (state_d != S_WAIT);
    valid_d = (state_d == S_RESP);
  end

  // State and registered outputs. Reset aborts an in-flight fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Instruction store write port. Reset does not clear the store.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign instr = instr_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// tb_instruction_fetch_responder
//   Drives two responders that share one clock, one reset and one load port.
//   Instance 0 uses WAIT_STATES=2 and instance 1 uses WAIT_STATES=0; both use
//   DEPTH_LOG2=8. A latency-countdown model predicts every output each cycle.
//   Directed literal checks pin the headline scenarios.
module tb_instruction_fetch_responder;

  localparam int NINST = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req  [NINST];
  logic [63:0] addr [NINST];
  logic        ready_o [NINST];
  logic        valid_o [NINST];
  logic [31:0] instr_o [NINST];
  logic        fault_o [NINST];
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [31:0] load_data = 32'h0;

  int checks = 0;
  int errors = 0;

  // Free-running clock; rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  instruction_fetch_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut_ws2 (
    .clock(clock), .reset(reset), .req(req[0]), .addr(addr[0]),
    .ready(ready_o[0]), .valid(valid_o[0]), .instr(instr_o[0]), .fault(fault_o[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instruction_fetch_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset(reset), .req(req[1]), .addr(addr[1]),
    .ready(ready_o[1]), .valid(valid_o[1]), .instr(instr_o[1]), .fault(fault_o[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Behavioural model. A request taken on an edge has a latency of 0 edges
  // if it faults and WAIT_STATES edges otherwise. While the latency runs,
  // the responder is busy. The response appears on the edge where the
  // latency reaches zero. The shadow store is read before it is written on
  // the same edge.
  logic [31:0] shadow [256];
  logic        m_ready   [NINST] = '{1'b1, 1'b1};
  logic        m_valid   [NINST] = '{1'b0, 1'b0};
  logic [31:0] m_instr   [NINST] = '{32'h0, 32'h0};
  logic        m_fault   [NINST] = '{1'b0, 1'b0};
  logic        m_pending [NINST] = '{1'b0, 1'b0};
  int          m_rem     [NINST] = '{0, 0};
  logic [7:0]  m_idx     [NINST] = '{8'd0, 8'd0};
  int          m_ws      [NINST] = '{2, 0};

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NINST; k++) begin
        m_ready[k]   = 1'b1;
        m_valid[k]   = 1'b0;
        m_instr[k]   = 32'h0;
        m_fault[k]   = 1'b0;
        m_pending[k] = 1'b0;
        m_rem[k]     = 0;
      end
    end else begin
      for (int k = 0; k < NINST; k++) begin
        logic [63:0] a;
        logic        take;
        take = req[k] && m_ready[k];
        a = addr[k];
        m_valid[k] = 1'b0;
        if (m_pending[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_pending[k] = 1'b0;
            m_valid[k]   = 1'b1;
            m_instr[k]   = shadow[m_idx[k]];
            m_fault[k]   = 1'b0;
          end
        end else if (take) begin
          if ((a % 64'd4 != 64'd0) || (a >= 64'd1024)) begin
            m_valid[k] = 1'b1;
            m_instr[k] = 32'h0;
            m_fault[k] = 1'b1;
          end else if (m_ws[k] == 0) begin
            m_valid[k] = 1'b1;
            m_instr[k] = shadow[a[9:2]];
            m_fault[k] = 1'b0;
          end else begin
            m_pending[k] = 1'b1;
            m_rem[k]     = m_ws[k];
            m_idx[k]     = a[9:2];
          end
        end
        m_ready[k] = !m_pending[k];
      end
      if (load_en) shadow[load_addr] = load_data;
    end
  end

  // Single comparison point, used by both the model compare and the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge, both instances are compared against the model.
  always @(negedge clock) begin
    for (int k = 0; k < NINST; k++) begin
      checkOutput($sformatf("model.ready[%0d]", k), 64'(ready_o[k]), 64'(m_ready[k]));
      checkOutput($sformatf("model.valid[%0d]", k), 64'(valid_o[k]), 64'(m_valid[k]));
      checkOutput($sformatf("model.instr[%0d]", k), 64'(instr_o[k]), 64'(m_instr[k]));
      checkOutput($sformatf("model.fault[%0d]", k), 64'(fault_o[k]), 64'(m_fault[k]));
    end
  end

  // Sets the request inputs for both instances.
  task automatic applyStimulus(input logic r0, input logic [63:0] a0,
                               input logic r1, input logic [63:0] a1);
    req[0]  = r0;
    addr[0] = a0;
    req[1]  = r1;
    addr[1] = a1;
  endtask

  // Advances past one rising edge. Inputs are driven, and outputs are sampled, 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks one instance against literal expectations for all four outputs.
  task automatic expectAll(input string tag, input int k, input logic rdy, input logic vld,
                           input logic [31:0] ins, input logic flt);
    checkOutput({tag, ".ready"}, 64'(ready_o[k]), 64'(rdy));
    checkOutput({tag, ".valid"}, 64'(valid_o[k]), 64'(vld));
    checkOutput({tag, ".instr"}, 64'(instr_o[k]), 64'(ins));
    checkOutput({tag, ".fault"}, 64'(fault_o[k]), 64'(flt));
  endtask

  // Directed scenario sequence with hand-computed expectations.
  initial begin
    logic [31:0] prog [4];
    prog = '{32'h8B020020, 32'hCB030041, 32'hF8400062, 32'hB4000040};
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);

    // Reset state
    #1 reset = 1'b0;
    #1;
    expectAll("reset", 0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectAll("reset_ws0", 1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Program store[0..3]
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;

    // Single fetch of 0x8 with two wait states
    applyStimulus(1'b1, 64'h8, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    expectAll("fetch8.e0", 0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    expectAll("fetch8.e1", 0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    expectAll("fetch8.e2", 0, 1'b1, 1'b1, 32'hF8400062, 1'b0);
    tick();
    expectAll("fetch8.e3", 0, 1'b1, 1'b0, 32'hF8400062, 1'b0);

    // Back-to-back: req held with addr 0x4 during WAIT (ignored), taken in RESP
    applyStimulus(1'b1, 64'h0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b1, 64'h4, 1'b0, 64'h0);
    tick();
    checkOutput("b2b.wait_ready", 64'(ready_o[0]), 64'h0);
    tick();
    expectAll("b2b.first", 0, 1'b1, 1'b1, 32'h8B020020, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    expectAll("b2b.accept2", 0, 1'b0, 1'b0, 32'h8B020020, 1'b0);
    tick();
    tick();
    expectAll("b2b.second", 0, 1'b1, 1'b1, 32'hCB030041, 1'b0);

    // Faults answered one edge after acceptance, back to back from RESP
    applyStimulus(1'b1, 64'h6, 1'b0, 64'h0);
    tick();
    expectAll("mis6", 0, 1'b1, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 64'h400, 1'b0, 64'h0);
    tick();
    expectAll("oor400", 0, 1'b1, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
    tick();
    expectAll("oorTop", 0, 1'b1, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    expectAll("faultHold", 0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Collision: load word 3 on the edge that enters RESP for fetch 0xC
    applyStimulus(1'b1, 64'hC, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    load_en   = 1'b1;
    load_addr = 8'd3;
    load_data = 32'hD65F03C0;
    tick();
    load_en = 1'b0;
    expectAll("collide.old", 0, 1'b1, 1'b1, 32'hB4000040, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    tick();
    expectAll("collide.new", 0, 1'b1, 1'b1, 32'hD65F03C0, 1'b0);
    tick();

    // Reset during WAIT aborts the fetch asynchronously
    applyStimulus(1'b1, 64'h4, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    checkOutput("abort.in_wait", 64'(ready_o[0]), 64'h0);
    #1 reset = 1'b0;
    #1;
    expectAll("abort.async", 0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort.no_valid", 64'(valid_o[0]), 64'h0);
    end
    applyStimulus(1'b1, 64'h0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    tick();
    expectAll("retain.w0", 0, 1'b1, 1'b1, 32'h8B020020, 1'b0);
    tick();

    // Zero-wait instance: one response per cycle under continuous requests
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h4);
    tick();
    expectAll("ws0.a4", 1, 1'b1, 1'b1, 32'hCB030041, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h0);
    tick();
    expectAll("ws0.a0", 1, 1'b1, 1'b1, 32'h8B020020, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8);
    tick();
    expectAll("ws0.a8", 1, 1'b1, 1'b1, 32'hF8400062, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'hC);
    tick();
    expectAll("ws0.aC", 1, 1'b1, 1'b1, 32'hD65F03C0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h402);
    tick();
    expectAll("ws0.fault", 1, 1'b1, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    expectAll("ws0.idle", 1, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
